// File: rtl/puzzle_board_if.sv
// ----------------------------------------------------------------------------
// puzzle_board_if
//   Bundles the request and board-state signals of the sliding-tile puzzle
//   engine. The master (button front end / testbench) issues requests. The
//   slave (puzzle_board_ctrl) owns the board and reports its state.
//
//   Handshake: a request (shuffle or move_valid with move_dir) is taken on a
//   rising clk edge only when ready=1 at that edge. Requests seen while
//   ready=0 are dropped, not queued. ready falls on the accepting edge and
//   rises again once the engine is idle.
//
//   Signals
//     move_valid  master->slave  move request
//     move_dir    master->slave  0=UP 1=DOWN 2=LEFT 3=RIGHT
//     shuffle     master->slave  shuffle request (wins over move_valid)
//     pos_flat    slave->master  cell i tile at [4i+3:4i], 0 = blank
//     blank_idx   slave->master  index of the blank cell
//     move_count  slave->master  legal player moves since reset/shuffle
//     solved      slave->master  board is in the home layout
//     ready       slave->master  engine idle, request accepted this cycle
//     illegal     slave->master  one-cycle pulse for a move with no tile
// ----------------------------------------------------------------------------
interface puzzle_board_if #(
   parameter int CNT_W = 16
);
   logic             move_valid;
   logic [1:0]       move_dir;
   logic             shuffle;
   logic [63:0]      pos_flat;
   logic [3:0]       blank_idx;
   logic [CNT_W-1:0] move_count;
   logic             solved;
   logic             ready;
   logic             illegal;

   modport master (
      output move_valid, move_dir, shuffle,
      input  pos_flat, blank_idx, move_count, solved, ready, illegal
   );

   modport slave (
      input  move_valid, move_dir, shuffle,
      output pos_flat, blank_idx, move_count, solved, ready, illegal
   );
endinterface

// File: rtl/puzzle_board_ctrl.sv
// ----------------------------------------------------------------------------
// puzzle_board_ctrl
//   Game-state engine for the 4x4 sliding-tile puzzle. Holds the 16-cell
//   board, applies player moves and LFSR-driven shuffles, and presents the
//   per-cell tile values to the display path.
//
//   Ports
//     clk        pixel clock, the only clock
//     rst        synchronous active-high reset
//     bus        puzzle_board_if slave: requests in, board state out
//     dbg_state  current FSM state (IDLE=0, SWAP=1, SHUF=2, CHECK=3)
//
//   Parameters
//     SHUFFLE_MOVES  legal random moves per shuffle (1..255)
//     LFSR_SEED      nonzero reset value of the 16-bit LFSR
//     CNT_W          width of move_count
// ----------------------------------------------------------------------------
module puzzle_board_ctrl #(
   parameter int          SHUFFLE_MOVES = 64,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1,
   parameter int          CNT_W         = 16
) (
   input  logic       clk,
   input  logic       rst,
   puzzle_board_if.slave bus,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWAP  = 2'd1,
      SHUF  = 2'd2,
      CHECK = 2'd3
   } state_t;

   state_t           state;
   logic [3:0]       cells [16];
   logic [3:0]       blank;
   logic [CNT_W-1:0] count;
   logic             solved_q;
   logic             ready_q;
   logic             illegal_q;
   logic [15:0]      lfsr;
   logic [7:0]       shuf_cnt;
   logic [1:0]       dir_q;

   logic [1:0]       cur_dir;
   logic [3:0]       src;
   logic             legal;
   logic             is_home;
   logic [15:0]      lfsr_next;

   // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
   assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

   // Source cell of the tile that would slide into the blank. Shuffle
   // attempts take their direction from the LFSR, player moves from the
   // direction latched on acceptance.
   always_comb begin
      cur_dir = (state == SHUF) ? lfsr[1:0] : dir_q;
      src     = blank;
      legal   = 1'b0;
      unique case (cur_dir)
         2'd0: begin legal = (blank[3:2] != 2'd3); src = blank + 4'd4; end
         2'd1: begin legal = (blank[3:2] != 2'd0); src = blank - 4'd4; end
         2'd2: begin legal = (blank[1:0] != 2'd3); src = blank + 4'd1; end
         2'd3: begin legal = (blank[1:0] != 2'd0); src = blank - 4'd1; end
      endcase
   end

   // Home layout: cell i holds i+1, last cell blank.
   always_comb begin
      is_home = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (cells[i] != 4'((i + 1) % 16)) is_home = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) cells[i] <= 4'((i + 1) % 16);
         blank     <= 4'd15;
         count     <= '0;
         solved_q  <= 1'b1;
         ready_q   <= 1'b1;
         illegal_q <= 1'b0;
         state     <= IDLE;
         lfsr      <= LFSR_SEED;
         shuf_cnt  <= '0;
         dir_q     <= 2'd0;
      end else begin
         lfsr      <= lfsr_next;
         illegal_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.shuffle) begin
                  shuf_cnt <= 8'(SHUFFLE_MOVES);
                  state    <= SHUF;
                  ready_q  <= 1'b0;
               end else if (bus.move_valid) begin
                  dir_q   <= bus.move_dir;
                  state   <= SWAP;
                  ready_q <= 1'b0;
               end
            end
            SWAP: begin
               if (legal) begin
                  cells[blank] <= cells[src];
                  cells[src]   <= 4'd0;
                  blank        <= src;
                  if (count != '1) count <= count + 1'b1;
               end else begin
                  illegal_q <= 1'b1;
               end
               state <= CHECK;
            end
            SHUF: begin
               // Illegal attempts are simply retried on the next LFSR value;
               // only legal moves consume the shuffle budget. move_count is
               // left alone here because it is cleared when the shuffle ends.
               if (legal) begin
                  cells[blank] <= cells[src];
                  cells[src]   <= 4'd0;
                  blank        <= src;
                  shuf_cnt     <= shuf_cnt - 8'd1;
                  if (shuf_cnt == 8'd1) begin
                     count <= '0;
                     state <= CHECK;
                  end
               end
            end
            CHECK: begin
               solved_q <= is_home;
               state    <= IDLE;
               ready_q  <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      bus.pos_flat = '0;
      for (int i = 0; i < 16; i++) bus.pos_flat[4*i +: 4] = cells[i];
   end

   assign bus.blank_idx  = blank;
   assign bus.move_count = count;
   assign bus.solved     = solved_q;
   assign bus.ready      = ready_q;
   assign bus.illegal    = illegal_q;
   assign dbg_state      = state;

endmodule

// File: tb/tb_puzzle_board_ctrl.sv
// ----------------------------------------------------------------------------
// tb_puzzle_board_ctrl
//   Self-checking bench for puzzle_board_ctrl. A board model (array of tile
//   values with row/column moves) predicts the final state of each request;
//   a monitor compares it when the engine returns to idle.
// ----------------------------------------------------------------------------
module tb_puzzle_board_ctrl;

   localparam int          N    = 64;
   localparam logic [15:0] SEED = 16'hACE1;
   localparam int          CW   = 16;
   // expectation: {pos 64, blank 4, count CW, solved 1, illegal pulses 8, busy cycles 16}
   localparam int          W    = 64 + 4 + CW + 1 + 8 + 16;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] dbg_state;

   always #5 clk = ~clk;

   puzzle_board_if #(.CNT_W(CW)) bus ();

   puzzle_board_ctrl #(
      .SHUFFLE_MOVES(N),
      .LFSR_SEED    (SEED),
      .CNT_W        (CW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .dbg_state(dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   logic [W-1:0] exp_q[$];

   int          m_cells [16];
   int          m_blank;
   int          m_count;
   logic [15:0] ref_lfsr;

   function automatic logic [15:0] lfsr_step(logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   always @(posedge clk) ref_lfsr <= rst ? SEED : lfsr_step(ref_lfsr);

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic void model_reset();
      for (int i = 0; i < 16; i++) m_cells[i] = (i + 1) % 16;
      m_blank = 15;
      m_count = 0;
   endfunction

   // Slide the neighbouring tile into the blank; the tile comes from the
   // side opposite to the named direction. Returns 0 when off the board.
   function automatic bit model_try(int dir);
      int row, col, nr, nc, s;
      row = m_blank / 4;
      col = m_blank % 4;
      nr  = row;
      nc  = col;
      case (dir)
         0: nr = row + 1;
         1: nr = row - 1;
         2: nc = col + 1;
         default: nc = col - 1;
      endcase
      if (nr < 0 || nr > 3 || nc < 0 || nc > 3) return 1'b0;
      s = nr * 4 + nc;
      m_cells[m_blank] = m_cells[s];
      m_cells[s]       = 0;
      m_blank          = s;
      return 1'b1;
   endfunction

   function automatic logic [63:0] model_flat();
      logic [63:0] f;
      f = '0;
      for (int i = 0; i < 16; i++) f[4*i +: 4] = 4'(m_cells[i]);
      return f;
   endfunction

   function automatic bit model_solved();
      for (int i = 0; i < 16; i++) if (m_cells[i] != (i + 1) % 16) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [W-1:0] pack_exp(int ill, int busy);
      return {model_flat(), 4'(m_blank), CW'(m_count), model_solved(), 8'(ill), 16'(busy)};
   endfunction

   // ---------------- monitor ----------------
   int busy_cnt = 0;
   int ill_cnt  = 0;

   always @(negedge clk) begin
      logic [W-1:0] e;
      logic [63:0]  p;
      logic [15:0]  seen;
      if (rst) begin
         busy_cnt = 0;
         ill_cnt  = 0;
      end else if (!bus.ready) begin
         busy_cnt++;
         if (bus.illegal) ill_cnt++;
      end else if (busy_cnt > 0) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: got busy=%0d expected no request", busy_cnt);
         end else begin
            e = exp_q.pop_front();
            p = bus.pos_flat;
            check("pos_flat",   p,                      e[W-1 -: 64]);
            check("blank_idx",  64'(bus.blank_idx),     64'(e[28+CW -: 4]));
            check("move_count", 64'(bus.move_count),    64'(e[24+CW -: CW]));
            check("solved",     64'(bus.solved),        64'(e[24]));
            check("illegal",    64'(ill_cnt),           64'(e[23:16]));
            check("busy",       64'(busy_cnt),          64'(e[15:0]));
            seen = '0;
            for (int i = 0; i < 16; i++) seen[p[4*i +: 4]] = 1'b1;
            check("permutation", 64'(seen), 64'(16'hFFFF));
            check("blank_cell", 64'(p[4*bus.blank_idx +: 4]), 64'd0);
         end
         busy_cnt = 0;
         ill_cnt  = 0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (bus.ready !== 1'b1 && n < 5000) begin
         tick();
         n++;
      end
      if (bus.ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got ready=%b state=%0d expected ready=1", bus.ready, dbg_state);
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_pos_flat",   bus.pos_flat,          64'h0FEDCBA987654321);
      check("rst_blank_idx",  64'(bus.blank_idx),    64'd15);
      check("rst_move_count", 64'(bus.move_count),   64'd0);
      check("rst_solved",     64'(bus.solved),       64'd1);
      check("rst_ready",      64'(bus.ready),        64'd1);
      check("rst_illegal",    64'(bus.illegal),      64'd0);
   endtask

   // hold: extra cycles move_valid stays high after acceptance (0..2)
   task automatic do_move(int dir, int hold);
      bit ok;
      wait_ready();
      bus.move_valid = 1'b1;
      bus.move_dir   = 2'(dir);
      ok = model_try(dir);
      if (ok && m_count < (1 << CW) - 1) m_count++;
      exp_q.push_back(pack_exp(ok ? 0 : 1, 2));
      tick();
      for (int h = 0; h < hold; h++) begin
         bus.move_dir = 2'($urandom_range(0, 3));
         tick();
      end
      bus.move_valid = 1'b0;
   endtask

   task automatic do_shuffle(bit with_move, bit mid_move);
      logic [15:0] l;
      int          k, left;
      wait_ready();
      bus.shuffle    = 1'b1;
      bus.move_valid = with_move;
      bus.move_dir   = 2'($urandom_range(0, 3));
      tick();
      bus.shuffle    = 1'b0;
      bus.move_valid = 1'b0;
      // ref_lfsr now holds the value the first shuffle attempt uses.
      l    = ref_lfsr;
      k    = 0;
      left = N;
      while (left > 0) begin
         if (model_try(int'(l[1:0]))) left--;
         k++;
         l = lfsr_step(l);
      end
      m_count = 0;
      exp_q.push_back(pack_exp(0, k + 1));
      if (mid_move) begin
         repeat (5) tick();
         bus.move_valid = 1'b1;
         bus.move_dir   = 2'($urandom_range(0, 3));
         tick();
         bus.move_valid = 1'b0;
      end
   endtask

   task automatic reset_mid_shuffle();
      wait_ready();
      bus.shuffle = 1'b1;
      tick();
      bus.shuffle = 1'b0;
      repeat ($urandom_range(5, 40)) tick();
      rst = 1'b1;
      tick();
      exp_q.delete();
      model_reset();
      check_reset_outputs();
      rst = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bus.move_valid = 1'b0;
      bus.move_dir   = 2'd0;
      bus.shuffle    = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      rst = 1'b0;

      do_move(1, 0);           // DOWN from home
      do_move(0, 2);           // UP back home, move_valid held through busy
      do_move(0, 0);           // UP at bottom row: illegal
      do_move(2, 1);           // LEFT at right column: illegal
      do_move(3, 0);           // RIGHT: legal
      do_move(2, 0);           // LEFT: back home

      do_shuffle(1'b1, 1'b1);  // shuffle wins over move, mid-shuffle move ignored
      repeat (40) do_move($urandom_range(0, 3), $urandom_range(0, 2));

      do_shuffle(1'b0, 1'b0);
      repeat (20) do_move($urandom_range(0, 3), 0);

      reset_mid_shuffle();
      do_move(1, 0);
      do_shuffle(1'b0, 1'b1);  // LFSR must have restarted from the seed
      repeat (20) do_move($urandom_range(0, 3), $urandom_range(0, 2));

      wait_ready();
      repeat (3) tick();
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got no finish, state=%0d expected completion", dbg_state);
      $fatal(1, "watchdog expired");
   end

endmodule
